reglk_writer: RTL and testbench
===============================

// Module: reglk_writer
// PURPOSE
//  Write side of the register-lock array: accepts lock-programming requests over a valid/ready bus and drives reglk_mem_o.
//  Lock bits are set-only (sticky). A commit freezes the whole array.
//  Only the global reset or a sustained, qualified JTAG unlock clears the array.
//  The module-local soft reset recovers the FSM only and never clears locks (CWE-1231 hardening).
// PARAMETERS
//  NUM_WORDS      6             number of 32-bit lock words; legal addr 0..NUM_WORDS-1
//  COMMIT_KEY     32'hC0DE_10CC required wdata for a commit write to addr NUM_WORDS
//  UNLOCK_CYCLES  16            consecutive jtag_unlock_i cycles needed to clear the array (>=2)
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          global reset, asynchronous, active-low
//  soft_rst_i     in   1          module-local synchronous soft reset, FSM only
//  jtag_unlock_i  in   1          debug unlock request (level)
//  req_valid_i    in   1          request valid
//  req_ready_o    out  1          request ready
//  req_we_i       in   1          1=write, 0=read
//  req_addr_i     in   3          word address (width fixed for NUM_WORDS<=7)
//  req_wdata_i    in   32         write data
//  rsp_valid_o    out  1          response valid
//  rsp_ready_i    in   1          response accepted
//  rsp_rdata_o    out  32         read data (0 for writes and errors)
//  rsp_err_o      out  1          request rejected
//  reglk_mem_o    out  32xNUM_WORDS  lock words to the protected registers
//  committed_o    out  1          array frozen
// BEHAVIOUR
//  Reset (rst_ni=0, async)
//   - reglk_mem_o all 0; committed_o=0; FSM=IDLE; unlock counter=0.
//   - req_ready_o=0 during reset; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//   - IDLE: req_ready_o=1. A handshake (valid&&ready) captures we/addr/wdata and moves to ACCESS.
//   - ACCESS: one cycle, req_ready_o=0. Performs the operation and registers rdata/err. Moves to RESP.
//   - RESP: rsp_valid_o=1, outputs held stable until rsp_ready_i=1; then IDLE.
//   - Minimum request-to-rsp_valid latency is 2 cycles.
//  Write, addr<NUM_WORDS
//   - Not committed: mem[a] <= mem[a] | wdata; err=0. Bits are never cleared by any write.
//   - Committed: mem unchanged; err=1.
//  Write, addr==NUM_WORDS
//   - wdata==COMMIT_KEY: committed<=1; err=0. Re-commit is harmless: err=0.
//   - Any other data: no change; err=1.
//  Read
//   - addr<NUM_WORDS: rdata=mem[a].
//   - addr==NUM_WORDS: rdata={31'b0,committed}.
//   - Reads are always permitted, including after commit.
//  Any addr>NUM_WORDS (read or write): err=1, rdata=0, no state change.
//  Unlock
//   - The counter increments each cycle jtag_unlock_i=1, saturating at UNLOCK_CYCLES. Any cycle with 0 resets it to 0.
//   - On the cycle the count reaches UNLOCK_CYCLES: all mem<=0 and committed<=0, once per assertion.
//   - Unlock takes priority over a same-cycle ACCESS write; that write is discarded and err=1.
//  Soft reset (soft_rst_i=1)
//   - FSM->IDLE; any pending response is dropped (rsp_valid_o=0 next cycle); unlock counter=0.
//   - reglk_mem_o and committed_o are NOT modified.
//  reglk_mem_o and committed_o are direct register outputs (no combinational path from inputs).
// TESTING
//  T1: after reset, write a0 d=32'h0000_00F0, then a0 d=32'h0000_000F -> mem[0]=32'h0000_00FF; both rsp_err_o=0.
//  T2: write addr6 d=COMMIT_KEY, then write a1 d=1 -> committed_o=1; second rsp_err_o=1; mem[1] unchanged; read a1 succeeds.
//  T3: set mem[2]=32'hFFFF_0000; pulse soft_rst_i mid-RESP -> rsp_valid_o drops; mem[2] still 32'hFFFF_0000; committed_o unchanged.
//  T4: jtag_unlock_i high 15 cycles, low 1, high 16 -> array clears only on the 16th consecutive cycle; a second clear requires a new run of 16.
//  T5: write addr7, and write addr6 d=32'h1234_5678 -> both rsp_err_o=1, rsp_rdata_o=0, no state change.
//  T6: hold rsp_ready_i=0 for 5 cycles -> rsp outputs stable and req_ready_o=0 throughout; assert rst_ni=0 mid-request -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reglk_writer.sv
`default_nettype none
// ============================================================================
// Module   : reglk_writer
// Brief    : Write side of the register-lock array. Lock bits are sticky,
//            a commit freezes the array, and only global reset or a sustained
//            JTAG unlock clears it.
// Revision : 1.0
// ============================================================================
module reglk_writer #(
  parameter int          NUM_WORDS     = 6,
  parameter logic [31:0] COMMIT_KEY    = 32'hC0DE_10CC,
  parameter int          UNLOCK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    soft_rst_i,
  input  logic                    jtag_unlock_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [2:0]              req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [32*NUM_WORDS-1:0] reglk_mem_o,
  output logic                    committed_o
);

  localparam int                 c_cnt_w       = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [2:0]         c_commit_addr = 3'(NUM_WORDS);
  localparam logic [c_cnt_w-1:0] c_cnt_max     = c_cnt_w'(UNLOCK_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_fire    = c_cnt_w'(UNLOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_req_ready;
  logic                 r_we;
  logic [2:0]           r_addr;
  logic [31:0]          r_wdata;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_rdata;
  logic                 r_rsp_err;
  logic [c_cnt_w-1:0]   r_unlock_cnt;
  logic                 r_committed;
  logic [31:0]          r_mem [NUM_WORDS];

  logic                 w_unlock_fire;
  logic                 w_access_wr;
  logic                 w_word_wr;
  logic                 w_commit_wr;
  logic [31:0]          w_rd_word;
  logic [31:0]          w_acc_rdata;
  logic                 w_acc_err;

  // Fires exactly once per assertion: the counter saturates past this value.
  assign w_unlock_fire = jtag_unlock_i && !soft_rst_i && (r_unlock_cnt == c_cnt_fire);

  assign w_access_wr = (r_state == ST_ACCESS) && r_we && !soft_rst_i && !w_unlock_fire;
  assign w_word_wr   = w_access_wr && (r_addr < c_commit_addr) && !r_committed;
  assign w_commit_wr = w_access_wr && (r_addr == c_commit_addr) && (r_wdata == COMMIT_KEY);

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (r_addr == 3'(i)) w_rd_word = r_mem[i];
    end
  end

  always_comb begin
    w_acc_rdata = '0;
    w_acc_err   = 1'b0;
    if (r_addr > c_commit_addr) begin
      w_acc_err = 1'b1;
    end else if (!r_we) begin
      w_acc_rdata = (r_addr == c_commit_addr) ? {31'b0, r_committed} : w_rd_word;
    end else if (w_unlock_fire) begin
      w_acc_err = 1'b1;
    end else if (r_addr == c_commit_addr) begin
      w_acc_err = (r_wdata != COMMIT_KEY);
    end else begin
      w_acc_err = r_committed;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (soft_rst_i) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid_i && r_req_ready) begin
            r_we        <= req_we_i;
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_req_ready <= 1'b0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_acc_rdata;
          r_rsp_err   <= w_acc_err;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_unlock_cnt <= '0;
    end else if (soft_rst_i || !jtag_unlock_i) begin
      r_unlock_cnt <= '0;
    end else if (r_unlock_cnt != c_cnt_max) begin
      r_unlock_cnt <= r_unlock_cnt + c_cnt_w'(1);
    end
  end

  // Soft reset deliberately has no path into the lock state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
      r_committed <= 1'b0;
    end else if (w_unlock_fire) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
      r_committed <= 1'b0;
    end else begin
      if (w_word_wr) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (r_addr == 3'(i)) r_mem[i] <= r_mem[i] | r_wdata;
        end
      end
      if (w_commit_wr) r_committed <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_mem_out
    assign reglk_mem_o[32*gi +: 32] = r_mem[gi];
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign committed_o = r_committed;

endmodule
`default_nettype wire

// File: tb/tb_reglk_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reglk_writer
// Brief    : Self-checking bench for reglk_writer: vector table, directed
//            multi-cycle sequences and randomized traffic against a model.
// Revision : 1.0
// ============================================================================
module tb_reglk_writer;

  localparam int          NUM_WORDS = 6;
  localparam logic [31:0] KEY       = 32'hC0DE_10CC;
  localparam int          UNLOCK    = 16;
  localparam int          NVEC      = 14;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    soft_rst;
  logic                    jtag;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_addr;
  logic [31:0]             req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic [32*NUM_WORDS-1:0] mem_o;
  logic                    committed;

  always #5 clk = ~clk;

  reglk_writer #(
    .NUM_WORDS     (NUM_WORDS),
    .COMMIT_KEY    (KEY),
    .UNLOCK_CYCLES (UNLOCK)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .soft_rst_i    (soft_rst),
    .jtag_unlock_i (jtag),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .reglk_mem_o   (mem_o),
    .committed_o   (committed)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        tbl [NVEC];
  logic [31:0] m_mem [NUM_WORDS];
  logic        m_commit;
  int          n_checks = 0;
  int          n_errs   = 0;

  logic [31:0] rd, erd, wd;
  logic        er, eer, we;
  logic [2:0]  addr;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    for (int i = 0; i < NUM_WORDS; i++)
      chk32($sformatf("%s mem[%0d]", tag, i), mem_o[32*i +: 32], m_mem[i]);
    chk1($sformatf("%s committed", tag), committed, m_commit);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_WORDS; i++) m_mem[i] = '0;
    m_commit = 1'b0;
  endtask

  // Reference behaviour of one request, straight from the access rules.
  task automatic model_apply(input logic w, input logic [2:0] a, input logic [31:0] d,
                             input logic unlock_now, output logic [31:0] r, output logic e);
    r = '0;
    e = 1'b0;
    if (int'(a) > NUM_WORDS) e = 1'b1;
    else if (!w) r = (int'(a) == NUM_WORDS) ? {31'b0, m_commit} : m_mem[a];
    else if (unlock_now) e = 1'b1;
    else if (int'(a) == NUM_WORDS) begin
      e = (d != KEY);
      if (!e) m_commit = 1'b1;
    end else begin
      e = m_commit;
      if (!m_commit) m_mem[a] = m_mem[a] | d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    soft_rst = 1'b0;
    jtag = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic do_req(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input int delay, output logic [31:0] r, output logic e);
    int t;
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk1("req_ready_low_access", req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rsp_valid_latency", rsp_valid, 1'b1);
    r = rsp_rdata;
    e = rsp_err;
    repeat (delay) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk1("rsp_valid_after_accept", rsp_valid, 1'b0);
  endtask

  task automatic set_vec(input int i, input logic w, input logic [2:0] a, input logic [31:0] d,
                         input logic e, input logic [31:0] r);
    tbl[i] = '{we: w, addr: a, wdata: d, err: e, rdata: r};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_vec(0,  1'b1, 3'd0, 32'h0000_00F0, 1'b0, 32'h0);
    set_vec(1,  1'b1, 3'd0, 32'h0000_000F, 1'b0, 32'h0);
    set_vec(2,  1'b0, 3'd0, 32'h0,         1'b0, 32'h0000_00FF);
    set_vec(3,  1'b1, 3'd7, 32'h0000_1234, 1'b1, 32'h0);
    set_vec(4,  1'b0, 3'd7, 32'h0,         1'b1, 32'h0);
    set_vec(5,  1'b1, 3'd6, 32'h1234_5678, 1'b1, 32'h0);
    set_vec(6,  1'b0, 3'd6, 32'h0,         1'b0, 32'h0);
    set_vec(7,  1'b1, 3'd2, 32'hFFFF_0000, 1'b0, 32'h0);
    set_vec(8,  1'b1, 3'd6, KEY,           1'b0, 32'h0);
    set_vec(9,  1'b0, 3'd6, 32'h0,         1'b0, 32'h1);
    set_vec(10, 1'b1, 3'd1, 32'h0000_0001, 1'b1, 32'h0);
    set_vec(11, 1'b0, 3'd1, 32'h0,         1'b0, 32'h0);
    set_vec(12, 1'b1, 3'd6, KEY,           1'b0, 32'h0);
    set_vec(13, 1'b0, 3'd2, 32'h0,         1'b0, 32'hFFFF_0000);

    rst_n = 1'b0; soft_rst = 1'b0; jtag = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    model_clear();
    #2;
    chk1("reset req_ready", req_ready, 1'b0);
    chk1("reset rsp_valid", rsp_valid, 1'b0);
    chk32("reset rsp_rdata", rsp_rdata, 32'h0);
    chk1("reset rsp_err", rsp_err, 1'b0);
    chk_state("reset");
    do_reset();

    // Vector table: sticky OR, bad addresses, bad key, commit freeze.
    for (int i = 0; i < NVEC; i++) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, i % 3, rd, er);
      model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, erd, eer);
      chk32($sformatf("vec%0d rdata", i), rd, tbl[i].rdata);
      chk1($sformatf("vec%0d err", i), er, tbl[i].err);
      chk_state($sformatf("vec%0d", i));
    end

    // Soft reset during RESP drops the response but keeps locks.
    do_reset();
    do_req(1'b1, 3'd2, 32'hFFFF_0000, 0, rd, er);
    model_apply(1'b1, 3'd2, 32'hFFFF_0000, 1'b0, erd, eer);
    do_req(1'b1, 3'd6, KEY, 0, rd, er);
    model_apply(1'b1, 3'd6, KEY, 1'b0, erd, eer);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk1("soft rsp_valid before", rsp_valid, 1'b1);
    soft_rst = 1'b1;
    @(posedge clk); #1 soft_rst = 1'b0;
    chk1("soft rsp_valid dropped", rsp_valid, 1'b0);
    chk1("soft req_ready", req_ready, 1'b1);
    chk_state("soft");

    // Soft reset restarts the unlock run.
    jtag = 1'b1;
    repeat (10) @(posedge clk);
    #1 soft_rst = 1'b1;
    @(posedge clk); #1 soft_rst = 1'b0;
    repeat (UNLOCK - 1) @(posedge clk);
    #1 chk_state("soft_cnt no clear");
    @(posedge clk); #1;
    model_clear();
    chk_state("soft_cnt clear");
    jtag = 1'b0;

    // Unlock needs an unbroken run; a second clear needs a fresh run.
    do_req(1'b1, 3'd0, 32'h0000_00A5, 0, rd, er);
    model_apply(1'b1, 3'd0, 32'h0000_00A5, 1'b0, erd, eer);
    do_req(1'b1, 3'd6, KEY, 0, rd, er);
    model_apply(1'b1, 3'd6, KEY, 1'b0, erd, eer);
    jtag = 1'b1;
    repeat (UNLOCK - 1) @(posedge clk);
    #1 jtag = 1'b0;
    chk_state("unlock 15");
    @(posedge clk); #1 jtag = 1'b1;
    repeat (UNLOCK - 1) @(posedge clk);
    #1 chk_state("unlock run 15");
    @(posedge clk); #1;
    model_clear();
    chk_state("unlock run 16");
    do_req(1'b1, 3'd3, 32'h0000_0077, 0, rd, er);
    model_apply(1'b1, 3'd3, 32'h0000_0077, 1'b0, erd, eer);
    chk1("write while saturated err", er, eer);
    repeat (20) @(posedge clk);
    #1 chk_state("saturated no refire");
    jtag = 1'b0;
    @(posedge clk); #1 jtag = 1'b1;
    repeat (UNLOCK) @(posedge clk);
    #1 jtag = 1'b0;
    model_clear();
    chk_state("second unlock");

    // Unlock coinciding with the ACCESS cycle of a write.
    do_req(1'b1, 3'd4, 32'h0000_1100, 0, rd, er);
    model_apply(1'b1, 3'd4, 32'h0000_1100, 1'b0, erd, eer);
    jtag = 1'b1;
    repeat (UNLOCK - 2) @(posedge clk);
    #1 req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 32'h0000_003C;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    model_apply(1'b1, 3'd1, 32'h0000_003C, 1'b1, erd, eer);
    model_clear();
    chk1("prio rsp_valid", rsp_valid, 1'b1);
    chk1("prio err", rsp_err, eer);
    chk32("prio rdata", rsp_rdata, erd);
    chk_state("prio");
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0; jtag = 1'b0;

    // Randomized traffic with periodic unlock runs.
    for (int n = 0; n < 240; n++) begin
      if (n % 60 == 59) begin
        jtag = 1'b1;
        repeat (UNLOCK) @(posedge clk);
        #1 jtag = 1'b0;
        model_clear();
        chk_state("rand unlock");
      end
      we   = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7));
      wd   = $urandom & $urandom & $urandom;
      if (we && addr == 3'd6 && $urandom_range(0, 3) == 0) wd = KEY;
      do_req(we, addr, wd, int'($urandom_range(0, 3)), rd, er);
      model_apply(we, addr, wd, 1'b0, erd, eer);
      chk32($sformatf("rand%0d rdata", n), rd, erd);
      chk1($sformatf("rand%0d err", n), er, eer);
      chk_state($sformatf("rand%0d", n));
    end

    // Stalled response stays stable; async reset mid-request.
    do_reset();
    do_req(1'b1, 3'd0, 32'h5A5A_0001, 0, rd, er);
    model_apply(1'b1, 3'd0, 32'h5A5A_0001, 1'b0, erd, eer);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk1("stall rsp_valid", rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("stall%0d rsp_valid", k), rsp_valid, 1'b1);
      chk32($sformatf("stall%0d rdata", k), rsp_rdata, 32'h5A5A_0001);
      chk1($sformatf("stall%0d err", k), rsp_err, 1'b0);
      chk1($sformatf("stall%0d req_ready", k), req_ready, 1'b0);
    end
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    chk1("async rst req_ready", req_ready, 1'b0);
    chk1("async rst rsp_valid", rsp_valid, 1'b0);
    chk32("async rst rdata", rsp_rdata, 32'h0);
    chk1("async rst err", rsp_err, 1'b0);
    chk_state("async rst");
    @(posedge clk); #1 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
